// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
package serial_sub_pkg;

    // Sequencer states; encodings match the ALU-wide state numbering.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Bit counter width: must hold the value BUS_WIDTH itself without wrapping.
    function automatic int unsigned cnt_width(input int unsigned bus_width);
        return $clog2(bus_width) + 1;
    endfunction

endpackage

// File: rtl/serial_sub_fa.sv
// One-bit full adder cell used as the serial arithmetic element.
module serial_sub_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    // Sum and majority carry.
    always_comb begin
        s_o = a_i ^ b_i ^ c_i;
        c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: diff = a - b computed as a + ~b + 1, LSB first.
// The run phase lasts BUS_WIDTH+1 cycles: BUS_WIDTH bit-cycles followed by one
// cycle that resolves borrow/zero from the completed difference.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [BUS_WIDTH-1:0] a_i,
    input  logic [BUS_WIDTH-1:0] b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [BUS_WIDTH-1:0] diff_o,
    output logic                 borrow_o,
    output logic                 zero_o
);

    localparam int unsigned CntW = cnt_width(BUS_WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(BUS_WIDTH);

    state_e                state_q, state_d;
    logic [BUS_WIDTH-1:0]  a_sr_q;
    logic [BUS_WIDTH-1:0]  b_sr_q;
    logic [BUS_WIDTH-1:0]  diff_q;
    logic [CntW-1:0]       cnt_q;
    logic                  carry_q;
    logic                  carry_d;
    logic                  borrow_q;
    logic                  zero_q;
    logic                  sum;
    logic                  accept;
    logic                  bits_done;

    assign bits_done = (cnt_q == CntLast);

    // Bit cell: subtrahend is inverted here, the +1 comes from carry preset.
    serial_sub_fa u_fa (
        .a_i (a_sr_q[0]),
        .b_i (~b_sr_q[0]),
        .c_i (carry_q),
        .s_o (sum),
        .c_o (carry_d)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; start is only seen in IDLE and DONE.
    always_comb begin
        state_d = state_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    accept  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                busy_o = 1'b1;
                if (bits_done) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_o = 1'b1;
                if (start_i) begin
                    accept  = 1'b1;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath: operand capture, serial shift, bit counter, carry and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else if (accept) begin
            a_sr_q  <= a_i;
            b_sr_q  <= b_i;
            diff_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b1;
        end else if (state_q == StRun) begin
            if (!bits_done) begin
                a_sr_q  <= a_sr_q >> 1;
                b_sr_q  <= b_sr_q >> 1;
                diff_q  <= {sum, diff_q[BUS_WIDTH-1:1]};
                carry_q <= carry_d;
                cnt_q   <= cnt_q + CntW'(1);
            end else begin
                // Final carry out of a + ~b + 1 is set exactly when a >= b.
                borrow_q <= ~carry_q;
                zero_q   <= (diff_q == '0);
            end
        end
    end

    assign diff_o   = diff_q;
    assign borrow_o = borrow_q;
    assign zero_o   = zero_q;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: directed vectors, monitor checks at done.
module tb_serial_sub;

    localparam int unsigned W = 16;
    localparam int LATENCY = 17;

    typedef struct packed {
        logic [W-1:0] d;
        logic         br;
        logic         z;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int pushed = 0;
    exp_t sb[$];

    serial_sub #(.BUS_WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start),
        .a_i      (a),
        .b_i      (b),
        .busy_o   (busy),
        .done_o   (done),
        .diff_o   (diff),
        .borrow_o (borrow),
        .zero_o   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            exp_t e;
            done_seen++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got diff %0d with empty scoreboard", diff);
            end else begin
                e = sb.pop_front();
                if (diff !== e.d || borrow !== e.br || zero !== e.z) begin
                    errors++;
                    $display("FAIL result: got diff %0d borrow %0b zero %0b expected %0d %0b %0b",
                             diff, borrow, zero, e.d, e.br, e.z);
                end
            end
        end
    end

    // Called at a negedge: request an operation, accepted on the next posedge.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic push,
                         input logic [W-1:0] ed, input logic eb, input logic ez);
        exp_t e;
        start = 1'b1;
        a     = av;
        b     = bv;
        if (push) begin
            e.d  = ed;
            e.br = eb;
            e.z  = ez;
            sb.push_back(e);
            pushed++;
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = ~av;
        b     = av ^ bv;
    endtask

    // Called at the negedge after the accept edge; returns at the done cycle.
    task automatic wait_done(input int pulse_at);
        int lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            check("busy_run", busy, 1);
            if (lat == pulse_at) begin
                start = 1'b1;
                a     = 16'd9;
                b     = 16'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
        check("latency", lat, LATENCY);
        check("busy_in_done", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
        check("rst_zero", zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1. equal operands
        issue(16'd5, 16'd5, 1'b1, 16'd0, 1'b0, 1'b1);
        wait_done(-1);
        @(negedge clk);

        // 2. plain and wrapping subtraction
        issue(16'd300, 16'd44, 1'b1, 16'd256, 1'b0, 1'b0);
        wait_done(-1);
        @(negedge clk);
        issue(16'd0, 16'd1, 1'b1, 16'd65535, 1'b1, 1'b0);
        wait_done(-1);
        @(negedge clk);
        check("idle_hold_diff", diff, 65535);
        check("idle_hold_borrow", borrow, 1);
        check("idle_busy", busy, 0);

        // 3. extreme operands
        issue(16'd65535, 16'd65535, 1'b1, 16'd0, 1'b0, 1'b1);
        wait_done(-1);
        @(negedge clk);
        issue(16'd1, 16'd65535, 1'b1, 16'd2, 1'b1, 1'b0);
        wait_done(-1);
        @(negedge clk);

        // 4. start while busy is ignored
        issue(16'd50, 16'd8, 1'b1, 16'd42, 1'b0, 1'b0);
        wait_done(4);
        @(negedge clk);
        check("no_extra_run", busy, 0);
        repeat (20) @(negedge clk);

        // 5. back-to-back accept in the done cycle
        issue(16'd20, 16'd5, 1'b1, 16'd15, 1'b0, 1'b0);
        wait_done(-1);
        issue(16'd100, 16'd1, 1'b1, 16'd99, 1'b0, 1'b0);
        wait_done(-1);
        @(negedge clk);

        // 6. reset mid-run aborts without a done pulse
        issue(16'd1000, 16'd1, 1'b0, '0, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        issue(16'd7, 16'd2, 1'b1, 16'd5, 1'b0, 1'b0);
        wait_done(-1);
        repeat (3) @(negedge clk);

        check("done_count", done_seen, pushed);
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
